alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one registered ALU instance (1-cycle result latency, EN/OE gated) between NREQ requesters.
- Requesters are the decode/execute, address-gen and branch units.
- Arbitration is round-robin. The block latches operands and drives the ALU control pins, then captures the result and flags one cycle after issue.
- It returns the result on a per-requester valid/ready response channel. It is the only block allowed to drive ALU_EN/ALU_OE/ALU_OPCODE.

Parameters:
WIDTH  32  datapath width of A, B, result (must match the ALU instance)
NREQ   4   number of requesters, 2..8

Ports:
CLK         input   1           clock, all logic on posedge
RST_N       input   1           asynchronous active-low reset
REQ_VALID   input   NREQ        request valid, one bit per requester
REQ_READY   output  NREQ        request accepted (one-hot or zero)
REQ_OP      input   4*NREQ      packed opcodes, requester i at [4i+3:4i]
REQ_A       input   WIDTH*NREQ  packed operand A
REQ_B       input   WIDTH*NREQ  packed operand B
RSP_VALID   output  NREQ        response valid, one-hot or zero
RSP_READY   input   NREQ        response accepted by requester
RSP_DATA    output  WIDTH       result, shared bus, qualified by RSP_VALID
RSP_FLAGS   output  4           {CF,OF,SF,ZF} of result
RSP_ERR     output  1           1 = unsupported opcode, not executed
ALU_EN      output  1           ALU enable
ALU_OE      output  1           ALU output enable
ALU_OPCODE  output  4           opcode to ALU
ALU_A       output  WIDTH       operand A to ALU
ALU_B       output  WIDTH       operand B to ALU
ALU_OUT     input   WIDTH       ALU result
ALU_CF, ALU_OF, ALU_SF, ALU_ZF  input  1 each  ALU flags

Behaviour:
- Clock and reset: one clock, CLK. Reset RST_N is asynchronous, active-low.
- Reset values: state IDLE; rr pointer 0; REQ_READY 0; RSP_VALID 0; RSP_DATA 0; RSP_FLAGS 0; RSP_ERR 0; ALU_EN 0; ALU_OE 1; ALU_OPCODE 0; ALU_A 0; ALU_B 0.
- ALU_OE is held at 1 at all times. It is never driven 0, so the ALU never tristates.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - grant g = first i with REQ_VALID[i], searching from the rr pointer upward modulo NREQ.
  - REQ_READY[g] = 1 combinationally; all other REQ_READY bits are 0.
  - On handshake: latch REQ_OP/A/B[g] into ALU_OPCODE/ALU_A/ALU_B, latch g, set pointer = (g+1) mod NREQ.
  - Legal opcode (0x2..0x7: ADD, SUB, AND, OR, XOR, NOT): go to ISSUE.
  - Illegal opcode: go to RESP with RSP_ERR=1, RSP_DATA=0, RSP_FLAGS=0. The ALU is not enabled.
- ISSUE (1 cycle): ALU_EN=1 for exactly this cycle. The ALU registers its result at the closing edge.
- CAPTURE (1 cycle): ALU_EN=0, so the ALU holds. At the closing edge, sample ALU_OUT into RSP_DATA and {ALU_CF,ALU_OF,ALU_SF,ALU_ZF} into RSP_FLAGS; RSP_ERR=0.
- RESP:
  - RSP_VALID[g]=1; RSP_DATA/FLAGS/ERR are stable until accepted.
  - On RSP_READY[g], go to IDLE and drop RSP_VALID. RSP_READY of non-granted requesters is ignored.
- Latency: request handshake edge to RSP_VALID high is 3 cycles for legal ops, 1 cycle for illegal ops.
- Throughput: at most one op every 4 cycles. No REQ_READY is asserted outside IDLE.
- Simultaneous requests are resolved purely by the rr pointer. Pointer wrap-around from NREQ-1 goes to 0.
- A requester may drop REQ_VALID before the handshake; no state change results.
- RST_N asserted mid-operation: immediate return to reset values. The in-flight op is discarded, no response is issued and the pointer returns to 0.

Optional Feature:
- Macro: ALU_ARB_FLAG_RECALC_EN.
- Defined: in CAPTURE, RSP_FLAGS[1] (SF) = ALU_OUT[WIDTH-1] and RSP_FLAGS[0] (ZF) = (ALU_OUT==0), regenerated from the captured result. This compensates for ALU SF/ZF being derived from its previous-cycle result.
- Undefined: ALU_SF/ALU_ZF are passed through as sampled.
- CF/OF are passed through in both cases.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD=4'h2, OP_SUB=4'h3, OP_AND=4'h4, OP_OR=4'h5, OP_XOR=4'h6, OP_NOT=4'h7;
  - typedef enum arb_state_t {IDLE, ISSUE, CAPTURE, RESP};
  - flag struct alu_flags_t {cf, of, sf, zf};
  - function is_legal_op().
- One sub-module, rr_arbiter: combinational grant from the request vector and pointer, parameterised by NREQ. This sub-module is reused for other shared resources.

Test Plan:
- Single request, requester 1, ADD A=0x7FFFFFFF B=1 -> RSP_VALID=4'b0010 three cycles after handshake, RSP_DATA=0x80000000, CF=0.
- All four REQ_VALID held high with back-to-back RSP_READY=1 -> grants in order 0,1,2,3,0 and the pointer wraps; ALU_EN pulses exactly once per op.
- Requester 2 sends opcode 0xF -> RSP_VALID[2] one cycle after handshake, RSP_ERR=1, RSP_DATA=0, ALU_EN never 1.
- SUB A=5 B=5 with RSP_READY held low for 5 cycles -> RSP_DATA=0 and all RSP outputs stable throughout; REQ_READY stays 0 for all requesters.
- RST_N pulsed low during CAPTURE -> all outputs at reset values asynchronously, no RSP_VALID; next request from requester 3 is granted with pointer 0 search order.
- ALU_ARB_FLAG_RECALC_EN defined, AND A=0xF0 B=0x0F following a NOT op -> ZF=1, SF=0 regardless of ALU_SF/ALU_ZF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FSM states, flag bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} arb_state_t;

  typedef struct packed {
    logic cf;
    logic of;
    logic sf;
    logic zf;
  } alu_flags_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_NOT);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or above ptr_i, modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PtrW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  int            idx_w;
  logic [PtrW-1:0] idx;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx_w       = 0;
    idx         = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx_w = int'(ptr_i) + i;
      if (idx_w >= int'(NREQ)) idx_w = idx_w - int'(NREQ);
      idx = PtrW'(idx_w);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NREQ requesters.
// Optional ALU_ARB_FLAG_RECALC_EN regenerates SF/ZF from the captured result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       REQ_VALID,
  output logic [NREQ-1:0]       REQ_READY,
  input  logic [4*NREQ-1:0]     REQ_OP,
  input  logic [WIDTH*NREQ-1:0] REQ_A,
  input  logic [WIDTH*NREQ-1:0] REQ_B,
  output logic [NREQ-1:0]       RSP_VALID,
  input  logic [NREQ-1:0]       RSP_READY,
  output logic [WIDTH-1:0]      RSP_DATA,
  output logic [3:0]            RSP_FLAGS,
  output logic                  RSP_ERR,
  output logic                  ALU_EN,
  output logic                  ALU_OE,
  output logic [3:0]            ALU_OPCODE,
  output logic [WIDTH-1:0]      ALU_A,
  output logic [WIDTH-1:0]      ALU_B,
  input  logic [WIDTH-1:0]      ALU_OUT,
  input  logic                  ALU_CF,
  input  logic                  ALU_OF,
  input  logic                  ALU_SF,
  input  logic                  ALU_ZF
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state_q, state_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  gnt_q, gnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  alu_flags_t       flags_q, flags_d, cap_flags;
  logic             err_q, err_d;

  logic [NREQ-1:0]  gnt;
  logic [PtrW-1:0]  gnt_idx;
  logic             gnt_valid;
  logic [3:0]       gnt_op;
  logic [WIDTH-1:0] gnt_a, gnt_b;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .req_i      (REQ_VALID),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid)
  );

  assign gnt_op = REQ_OP[gnt_idx*4 +: 4];
  assign gnt_a  = REQ_A[gnt_idx*WIDTH +: WIDTH];
  assign gnt_b  = REQ_B[gnt_idx*WIDTH +: WIDTH];

  // The ALU derives SF/ZF from its previous result; recalc mode rebuilds them.
  always_comb begin
    cap_flags.cf = ALU_CF;
    cap_flags.of = ALU_OF;
`ifdef ALU_ARB_FLAG_RECALC_EN
    cap_flags.sf = ALU_OUT[WIDTH-1];
    cap_flags.zf = (ALU_OUT == '0);
`else
    cap_flags.sf = ALU_SF;
    cap_flags.zf = ALU_ZF;
`endif
  end

`ifdef ALU_ARB_FLAG_RECALC_EN
  logic unused_alu_flags;
  assign unused_alu_flags = ALU_SF ^ ALU_ZF;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    flags_d   = flags_q;
    err_d     = err_q;
    REQ_READY = '0;
    RSP_VALID = '0;
    ALU_EN    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          REQ_READY = gnt;
          op_d      = gnt_op;
          a_d       = gnt_a;
          b_d       = gnt_b;
          gnt_d     = gnt_idx;
          ptr_d     = (gnt_idx == PtrW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          if (is_legal_op(gnt_op)) begin
            state_d = ISSUE;
          end else begin
            state_d = RESP;
            data_d  = '0;
            flags_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        ALU_EN  = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        data_d  = ALU_OUT;
        flags_d = cap_flags;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        RSP_VALID[gnt_q] = 1'b1;
        if (RSP_READY[gnt_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign ALU_OE     = 1'b1;
  assign ALU_OPCODE = op_q;
  assign ALU_A      = a_q;
  assign ALU_B      = b_q;
  assign RSP_DATA   = data_q;
  assign RSP_FLAGS  = flags_q;
  assign RSP_ERR    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural registered ALU (stale SF/ZF).
module tb_alu_arbiter;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [3:0]   REQ_VALID, REQ_READY, RSP_VALID, RSP_READY;
  logic [15:0]  REQ_OP;
  logic [127:0] REQ_A, REQ_B;
  logic [31:0]  RSP_DATA, ALU_A, ALU_B;
  logic [3:0]   RSP_FLAGS, ALU_OPCODE;
  logic         RSP_ERR, ALU_EN, ALU_OE;
  logic [31:0]  alu_out = '0;
  logic         alu_cf = 1'b0, alu_of = 1'b0, alu_sf = 1'b0, alu_zf = 1'b1;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          en_cnt = 0;
  logic [31:0] prev_res = '0;

  logic [3:0]  mop[4];
  logic [31:0] ma[4], mb[4], mr[4];
  logic        mcf[4], mof[4];
  int          ord[8];

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(32), .NREQ(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_FLAGS(RSP_FLAGS), .RSP_ERR(RSP_ERR),
    .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_OPCODE(ALU_OPCODE),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OUT(alu_out),
    .ALU_CF(alu_cf), .ALU_OF(alu_of), .ALU_SF(alu_sf), .ALU_ZF(alu_zf)
  );

  function automatic logic [33:0] alu_f(input logic [3:0] op, input logic [31:0] a, b);
    logic [32:0] s;
    logic [31:0] r;
    logic        cf, of;
    s = '0; r = '0; cf = 1'b0; of = 1'b0;
    case (op)
      4'h2: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cf = s[32];
        of = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'h3: begin
        s = {1'b0, a} - {1'b0, b}; r = s[31:0]; cf = s[32];
        of = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~a;
      default: r = '0;
    endcase
    return {cf, of, r};
  endfunction

  // SF/ZF lag one result behind, as in the real ALU.
  always @(posedge CLK) begin
    if (ALU_EN) begin
      {alu_cf, alu_of, alu_out} <= alu_f(ALU_OPCODE, ALU_A, ALU_B);
      alu_sf <= alu_out[31];
      alu_zf <= (alu_out == 32'h0);
    end
  end

  function automatic logic [3:0] exp_flags(input logic cf, of, input logic [31:0] res, prev);
`ifdef ALU_ARB_FLAG_RECALC_EN
    return {cf, of, res[31], res == 32'h0};
`else
    return {cf, of, prev[31], prev == 32'h0};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (ALU_EN) en_cnt++;
    if ((RSP_VALID & RSP_READY) != 4'b0) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 64'(RSP_VALID), 64'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 64'(RSP_VALID), 64'(4'b0001 << e.idx));
        chk("rsp_data", 64'(RSP_DATA), 64'(e.data));
        chk("rsp_flags", 64'(RSP_FLAGS), 64'(e.flags));
        chk("rsp_err", 64'(RSP_ERR), 64'(e.err));
      end
    end
  end

  task automatic do_op(input int idx, input logic [3:0] op, input logic [31:0] a, b, r,
                       input logic cf, of, input int hold);
    exp_t e;
    int   w, lat, en0, other;
    logic legal;
    legal = (op >= 4'h2) && (op <= 4'h7);
    other = (idx + 1) % 4;
    e.idx = idx;
    e.data = legal ? r : 32'h0;
    e.flags = legal ? exp_flags(cf, of, r, prev_res) : 4'h0;
    e.err = !legal;
    if (legal) prev_res = r;
    sb.push_back(e);
    en0 = en_cnt;
    @(posedge CLK); #1;
    if (hold > 0) RSP_READY = 4'hF ^ (4'b0001 << idx);
    REQ_OP[4*idx +: 4] = op;
    REQ_A[32*idx +: 32] = a;
    REQ_B[32*idx +: 32] = b;
    REQ_VALID[idx] = 1'b1;
    w = 0;
    do begin @(negedge CLK); w++; end while (REQ_READY == 4'b0 && w < 20);
    chk("req_ready_grant", 64'(REQ_READY), 64'(4'b0001 << idx));
    @(posedge CLK); #1;
    REQ_VALID = '0;
    lat = 1;
    @(negedge CLK);
    chk("alu_opcode", 64'(ALU_OPCODE), 64'(op));
    chk("alu_a", 64'(ALU_A), 64'(a));
    chk("alu_b", 64'(ALU_B), 64'(b));
    chk("alu_en_issue", 64'(ALU_EN), 64'(legal));
    while (RSP_VALID == 4'b0 && lat < 10) begin
      @(posedge CLK); lat++; @(negedge CLK);
    end
    chk("latency", 64'(lat), legal ? 64'd3 : 64'd1);
    if (hold > 0) REQ_VALID[other] = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge CLK); @(negedge CLK);
      chk("hold_rsp_valid", 64'(RSP_VALID), 64'(4'b0001 << idx));
      chk("hold_rsp_data", 64'(RSP_DATA), 64'(e.data));
      chk("hold_rsp_flags", 64'(RSP_FLAGS), 64'(e.flags));
      chk("hold_rsp_err", 64'(RSP_ERR), 64'(e.err));
      chk("hold_req_ready", 64'(REQ_READY), 64'h0);
    end
    if (hold > 0) begin
      @(posedge CLK); #1;
      RSP_READY = 4'hF;
      REQ_VALID = '0;
    end
    @(posedge CLK); #1;
    chk("alu_en_pulses", 64'(en_cnt - en0), legal ? 64'd1 : 64'd0);
  endtask

  task automatic do_multi(input logic [3:0] mask, input int n);
    exp_t e;
    int   w, g, en0;
    en0 = en_cnt;
    for (int k = 0; k < n; k++) begin
      g = ord[k];
      e.idx = g;
      e.data = mr[g];
      e.flags = exp_flags(mcf[g], mof[g], mr[g], prev_res);
      e.err = 1'b0;
      prev_res = mr[g];
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      REQ_OP[4*i +: 4] = mop[i];
      REQ_A[32*i +: 32] = ma[i];
      REQ_B[32*i +: 32] = mb[i];
    end
    REQ_VALID = mask;
    for (int k = 0; k < n; k++) begin
      w = 0;
      do begin @(negedge CLK); w++; end while (REQ_READY == 4'b0 && w < 20);
      chk($sformatf("rr_grant%0d", k), 64'(REQ_READY), 64'(4'b0001 << ord[k]));
      @(posedge CLK);
    end
    #1;
    REQ_VALID = '0;
    w = 0;
    while (sb.size() != 0 && w < 100) begin @(negedge CLK); w++; end
    chk("rr_drain", 64'(sb.size()), 64'h0);
    @(posedge CLK); #1;
    chk("rr_alu_en_pulses", 64'(en_cnt - en0), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    RST_N = 1'b0; REQ_VALID = '0; RSP_READY = 4'hF;
    REQ_OP = '0; REQ_A = '0; REQ_B = '0;
    #3;
    chk("rst_req_ready", 64'(REQ_READY), 64'h0);
    chk("rst_rsp_valid", 64'(RSP_VALID), 64'h0);
    chk("rst_rsp_data", 64'(RSP_DATA), 64'h0);
    chk("rst_rsp_flags", 64'(RSP_FLAGS), 64'h0);
    chk("rst_rsp_err", 64'(RSP_ERR), 64'h0);
    chk("rst_alu_en", 64'(ALU_EN), 64'h0);
    chk("rst_alu_oe", 64'(ALU_OE), 64'h1);
    chk("rst_alu_ctl", 64'({ALU_OPCODE, ALU_A, ALU_B}), 64'h0);
    #20;
    RST_N = 1'b1;

    do_op(1, 4'h2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 0);
    do_op(2, 4'hF, 32'h1234, 32'h5678, 32'h0, 1'b0, 1'b0, 0);
    do_op(3, 4'h3, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0, 5);

    mop[0] = 4'h2; ma[0] = 32'hFFFF_FFFF; mb[0] = 32'h1;        mr[0] = 32'h0;
    mcf[0] = 1'b1; mof[0] = 1'b0;
    mop[1] = 4'h3; ma[1] = 32'h0;         mb[1] = 32'h1;        mr[1] = 32'hFFFF_FFFF;
    mcf[1] = 1'b1; mof[1] = 1'b0;
    mop[2] = 4'h6; ma[2] = 32'hA5A5_A5A5; mb[2] = 32'hFFFF_0000; mr[2] = 32'h5A5A_A5A5;
    mcf[2] = 1'b0; mof[2] = 1'b0;
    mop[3] = 4'h5; ma[3] = 32'h1234_0000; mb[3] = 32'h0000_5678; mr[3] = 32'h1234_5678;
    mcf[3] = 1'b0; mof[3] = 1'b0;
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;
    do_multi(4'hF, 5);

    do_op(0, 4'h8, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 0);
    do_op(1, 4'h1, 32'h1, 32'h1, 32'h0, 1'b0, 1'b0, 0);
    do_op(2, 4'h7, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'hFFFF_0000, 1'b0, 1'b0, 0);
    do_op(3, 4'h4, 32'hF0, 32'h0F, 32'h0, 1'b0, 1'b0, 0);

    // Abort an ADD in CAPTURE; the ALU has already executed it.
    @(posedge CLK); #1;
    REQ_OP[11:8] = 4'h2; REQ_A[95:64] = 32'h1; REQ_B[95:64] = 32'h2;
    REQ_VALID[2] = 1'b1;
    w = 0;
    do begin @(negedge CLK); w++; end while (REQ_READY == 4'b0 && w < 20);
    chk("abort_grant", 64'(REQ_READY), 64'h4);
    @(posedge CLK); #1;
    REQ_VALID = '0;
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    prev_res = 32'h3;
    chk("abort_rsp_valid", 64'(RSP_VALID), 64'h0);
    chk("abort_req_ready", 64'(REQ_READY), 64'h0);
    chk("abort_alu_en", 64'(ALU_EN), 64'h0);
    chk("abort_alu_oe", 64'(ALU_OE), 64'h1);
    chk("abort_alu_ctl", 64'({ALU_OPCODE, ALU_A, ALU_B}), 64'h0);
    chk("abort_rsp_out", 64'({RSP_DATA, RSP_FLAGS, RSP_ERR}), 64'h0);
    @(posedge CLK); #3;
    RST_N = 1'b1;

    mop[1] = 4'h3; ma[1] = 32'h8000_0000; mb[1] = 32'h1;        mr[1] = 32'h7FFF_FFFF;
    mcf[1] = 1'b0; mof[1] = 1'b1;
    mop[3] = 4'h2; ma[3] = 32'h4000_0000; mb[3] = 32'h4000_0000; mr[3] = 32'h8000_0000;
    mcf[3] = 1'b0; mof[3] = 1'b1;
    ord[0] = 1; ord[1] = 3;
    do_multi(4'b1010, 2);

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
